reg_decoder_seq: RTL and testbench

//  Parametrised, registered SEL_W-to-NUM_OUT one-hot decoder for chip/bank select in the Hack datapath.
//  Two modes: DIRECT (decode an accepted sel, hold result) and SCAN (auto-step one-hot through every output, then stop).

---
 rtl/reg_decoder_seq.sv | 111 +++++++++++
 tb/tb_reg_decoder_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_decoder_seq.sv
// reg_decoder_seq: registered SEL_W-to-NUM_OUT one-hot decoder with DIRECT and SCAN modes.
// Define DECODER_RANGE_CHECK_EN to enable the sticky out-of-range err flag (err tied low otherwise).
module reg_decoder_seq #(
   parameter int SEL_W   = 3,
   parameter int NUM_OUT = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               clear,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [SEL_W-1:0]   sel,
   input  logic               scan_start,
   output logic [NUM_OUT-1:0] o,
   output logic               out_valid,
   output logic               scan_done,
   output logic               err
);

   typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

   // Scan terminates on an explicit compare so NUM_OUT need not be a power of two.
   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_OUT - 1);

   state_t             state, state_nxt;
   logic [SEL_W-1:0]   cnt, cnt_nxt;
   logic [NUM_OUT-1:0] o_nxt;
   logic               vld_nxt;
   logic               done_nxt;

   function automatic logic [NUM_OUT-1:0] decode(input logic [SEL_W-1:0] idx);
      logic [NUM_OUT-1:0] d;
      for (int i = 0; i < NUM_OUT; i++) d[i] = (int'(idx) == i);
      return d;
   endfunction

   assign in_ready = (state == IDLE) && !scan_start;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      o_nxt     = o;
      vld_nxt   = 1'b0;
      done_nxt  = 1'b0;
      unique case (state)
         IDLE: begin
            if (scan_start) begin
               state_nxt = SCAN;
               cnt_nxt   = '0;
            end else if (in_valid) begin
               o_nxt   = decode(sel);
               vld_nxt = 1'b1;
            end
         end
         SCAN: begin
            if (en) begin
               o_nxt   = decode(cnt);
               vld_nxt = 1'b1;
               if (cnt == LAST_IDX) begin
                  cnt_nxt   = '0;
                  done_nxt  = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  cnt_nxt = cnt + SEL_W'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      // A step taken during clear still advances cnt/state but never reaches o.
      if (clear) begin
         o_nxt   = '0;
         vld_nxt = 1'b0;
      end
   end

   // Output register stage
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         o         <= '0;
         out_valid <= 1'b0;
         scan_done <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         o         <= o_nxt;
         out_valid <= vld_nxt;
         scan_done <= done_nxt;
      end
   end

`ifdef DECODER_RANGE_CHECK_EN
   logic err_q;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         err_q <= 1'b0;
      end else if (in_valid && in_ready && (int'(sel) >= NUM_OUT)) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_reg_decoder_seq.sv
// Self-checking bench for reg_decoder_seq: directed scenarios plus randomized traffic against a reference model.
// Two instances run on shared stimulus: NUM_OUT=8 (full range) and NUM_OUT=6 (out-of-range selects exist).
module tb_reg_decoder_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, en, clear, in_valid, scan_start;
   logic [2:0] sel;
   logic       in_ready8, ov8, sd8, err8;
   logic       in_ready6, ov6, sd6, err6;
   logic [7:0] o8;
   logic [5:0] o6;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef DECODER_RANGE_CHECK_EN
   localparam logic RC = 1'b1;
`else
   localparam logic RC = 1'b0;
`endif

   reg_decoder_seq #(.SEL_W(3), .NUM_OUT(8)) dut (
      .clk(clk), .reset(reset), .en(en), .clear(clear), .in_valid(in_valid), .in_ready(in_ready8),
      .sel(sel), .scan_start(scan_start), .o(o8), .out_valid(ov8), .scan_done(sd8), .err(err8));

   reg_decoder_seq #(.SEL_W(3), .NUM_OUT(6)) dut6 (
      .clk(clk), .reset(reset), .en(en), .clear(clear), .in_valid(in_valid), .in_ready(in_ready6),
      .sel(sel), .scan_start(scan_start), .o(o6), .out_valid(ov6), .scan_done(sd6), .err(err6));

   // Reference model: index 0 models NUM_OUT=8, index 1 models NUM_OUT=6.
   bit         m_scan [2] = '{0, 0};
   int         m_idx  [2] = '{0, 0};
   logic [7:0] m_o    [2] = '{8'h00, 8'h00};
   logic       m_vld  [2] = '{1'b0, 1'b0};
   logic       m_done [2] = '{1'b0, 1'b0};
   logic       m_err  [2] = '{1'b0, 1'b0};

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         int         n;
         logic [7:0] nxt;
         bit         oor;
         n = (k == 0) ? 8 : 6;
         if (reset) begin
            m_scan[k] = 0; m_idx[k] = 0; m_o[k] = 8'h00;
            m_vld[k] = 1'b0; m_done[k] = 1'b0; m_err[k] = 1'b0;
         end else begin
            nxt = m_o[k]; oor = 0;
            m_vld[k] = 1'b0; m_done[k] = 1'b0;
            if (!m_scan[k]) begin
               if (scan_start) begin
                  m_scan[k] = 1; m_idx[k] = 0;
               end else if (in_valid) begin
                  nxt = (int'(sel) < n) ? (8'd1 << sel) : 8'd0;
                  m_vld[k] = 1'b1;
                  oor = (int'(sel) >= n);
               end
            end else if (en) begin
               nxt = 8'd1 << m_idx[k];
               m_vld[k] = 1'b1;
               if (m_idx[k] == n - 1) begin
                  m_done[k] = 1'b1; m_scan[k] = 0; m_idx[k] = 0;
               end else begin
                  m_idx[k] = m_idx[k] + 1;
               end
            end
            if (clear) begin
               nxt = 8'h00; m_vld[k] = 1'b0; m_err[k] = 1'b0;
            end else if (oor && RC) begin
               m_err[k] = 1'b1;
            end
            m_o[k] = nxt;
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      en = 1'b0; clear = 1'b0; in_valid = 1'b0; scan_start = 1'b0; sel = 3'd0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      reset = 1'b1;
      cyc(); cyc();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      cyc(); cyc();
      n_tests++; if (o8 !== 8'h00) begin n_fail++; $display("FAIL reset_o8 got %h want 00", o8); end
      n_tests++; if (ov8 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", ov8); end
      n_tests++; if (sd8 !== 1'b0) begin n_fail++; $display("FAIL reset_scan_done got %b want 0", sd8); end
      n_tests++; if (err8 !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err8); end
      n_tests++; if (in_ready8 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready8); end
      n_tests++; if (o6 !== 6'h00 || err6 !== 1'b0) begin n_fail++; $display("FAIL reset_dut6 got o=%h err=%b want 00/0", o6, err6); end
      reset = 1'b0;
   endtask

   task automatic test_direct();
      apply_reset();
      sel = 3'd5; in_valid = 1'b1;
      #1;
      n_tests++; if (in_ready8 !== 1'b1) begin n_fail++; $display("FAIL direct_in_ready got %b want 1", in_ready8); end
      cyc();
      in_valid = 1'b0;
      n_tests++; if (o8 !== 8'b0010_0000) begin n_fail++; $display("FAIL direct_o got %h want 20", o8); end
      n_tests++; if (ov8 !== 1'b1) begin n_fail++; $display("FAIL direct_out_valid got %b want 1", ov8); end
      n_tests++; if (o6 !== 6'b10_0000 || ov6 !== 1'b1) begin n_fail++; $display("FAIL direct_dut6 got o=%h v=%b want 20/1", o6, ov6); end
      cyc();
      n_tests++; if (o8 !== 8'h20 || ov8 !== 1'b0) begin n_fail++; $display("FAIL direct_hold got o=%h v=%b want 20/0", o8, ov8); end
   endtask

   task automatic test_scan();
      apply_reset();
      scan_start = 1'b1; en = 1'b1;
      #1;
      n_tests++; if (in_ready8 !== 1'b0) begin n_fail++; $display("FAIL scan_start_in_ready got %b want 0", in_ready8); end
      cyc();
      scan_start = 1'b0;
      n_tests++; if (ov8 !== 1'b0) begin n_fail++; $display("FAIL scan_enter_valid got %b want 0", ov8); end
      for (int i = 0; i < 8; i++) begin
         logic [7:0] exp_o;
         exp_o = 8'd1 << i;
         cyc();
         n_tests++; if (o8 !== exp_o || ov8 !== 1'b1) begin n_fail++; $display("FAIL scan_step%0d got o=%h v=%b want %h/1", i, o8, ov8, exp_o); end
         n_tests++; if (sd8 !== (i == 7)) begin n_fail++; $display("FAIL scan_done8_step%0d got %b want %b", i, sd8, (i == 7)); end
         n_tests++; if (sd6 !== (i == 5)) begin n_fail++; $display("FAIL scan_done6_step%0d got %b want %b", i, sd6, (i == 5)); end
      end
      en = 1'b0;
      #1;
      n_tests++; if (in_ready8 !== 1'b1) begin n_fail++; $display("FAIL scan_after_in_ready got %b want 1", in_ready8); end
      cyc();
      n_tests++; if (o8 !== 8'h80 || ov8 !== 1'b0 || sd8 !== 1'b0) begin n_fail++; $display("FAIL scan_after_hold got o=%h v=%b d=%b want 80/0/0", o8, ov8, sd8); end
   endtask

   task automatic test_en_gap();
      apply_reset();
      scan_start = 1'b1; en = 1'b1;
      cyc();
      scan_start = 1'b0;
      cyc(); cyc(); cyc();
      n_tests++; if (o8 !== 8'h04) begin n_fail++; $display("FAIL gap_pre got %h want 04", o8); end
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         n_tests++; if (o8 !== 8'h04 || ov8 !== 1'b0) begin n_fail++; $display("FAIL gap_hold%0d got o=%h v=%b want 04/0", i, o8, ov8); end
      end
      en = 1'b1;
      cyc();
      n_tests++; if (o8 !== 8'h08 || ov8 !== 1'b1) begin n_fail++; $display("FAIL gap_resume got o=%h v=%b want 08/1", o8, ov8); end
      cyc(); cyc(); cyc(); cyc();
      n_tests++; if (o8 !== 8'h80 || sd8 !== 1'b1) begin n_fail++; $display("FAIL gap_done got o=%h d=%b want 80/1", o8, sd8); end
      en = 1'b0;
   endtask

   task automatic test_range();
      apply_reset();
      sel = 3'd7; in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      n_tests++; if (o6 !== 6'h00 || ov6 !== 1'b1) begin n_fail++; $display("FAIL range_o6 got o=%h v=%b want 00/1", o6, ov6); end
      n_tests++; if (err6 !== RC) begin n_fail++; $display("FAIL range_err6 got %b want %b", err6, RC); end
      n_tests++; if (o8 !== 8'h80 || err8 !== 1'b0) begin n_fail++; $display("FAIL range_dut8 got o=%h err=%b want 80/0", o8, err8); end
      sel = 3'd5; in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      n_tests++; if (o6 !== 6'h20 || err6 !== RC) begin n_fail++; $display("FAIL range_sticky got o=%h err=%b want 20/%b", o6, err6, RC); end
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      n_tests++; if (err6 !== 1'b0 || o6 !== 6'h00 || ov6 !== 1'b0) begin n_fail++; $display("FAIL range_clear got err=%b o=%h v=%b want 0/00/0", err6, o6, ov6); end
      sel = 3'd6; in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      n_tests++; if (o6 !== 6'h00 || err6 !== RC || o8 !== 8'h40) begin n_fail++; $display("FAIL range_edge got o6=%h err=%b o8=%h want 00/%b/40", o6, err6, o8, RC); end
   endtask

   task automatic test_collision();
      apply_reset();
      sel = 3'd3; in_valid = 1'b1;
      cyc();
      scan_start = 1'b1; in_valid = 1'b1; sel = 3'd2; en = 1'b0;
      #1;
      n_tests++; if (in_ready8 !== 1'b0) begin n_fail++; $display("FAIL coll_in_ready got %b want 0", in_ready8); end
      cyc();
      scan_start = 1'b0; in_valid = 1'b0;
      n_tests++; if (o8 !== 8'h08 || ov8 !== 1'b0) begin n_fail++; $display("FAIL coll_dropped got o=%h v=%b want 08/0", o8, ov8); end
      en = 1'b1;
      cyc();
      n_tests++; if (o8 !== 8'h01 || ov8 !== 1'b1) begin n_fail++; $display("FAIL coll_scan_first got o=%h v=%b want 01/1", o8, ov8); end
      cyc(); cyc(); cyc();
      n_tests++; if (o8 !== 8'h08) begin n_fail++; $display("FAIL coll_mid got %h want 08", o8); end
      reset = 1'b1;
      cyc();
      n_tests++; if (o8 !== 8'h00 || ov8 !== 1'b0 || sd8 !== 1'b0 || in_ready8 !== 1'b1) begin n_fail++; $display("FAIL coll_reset got o=%h v=%b d=%b r=%b want 00/0/0/1", o8, ov8, sd8, in_ready8); end
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         n_tests++; if (ov8 !== 1'b0 || sd8 !== 1'b0) begin n_fail++; $display("FAIL coll_post%0d got v=%b d=%b want 0/0", i, ov8, sd8); end
      end
      en = 1'b0;
   endtask

   task automatic test_random();
      apply_reset();
      for (int i = 0; i < 600; i++) begin
         reset      = ($urandom_range(0, 99) == 0);
         clear      = ($urandom_range(0, 19) == 0);
         en         = ($urandom_range(0, 9) < 7);
         in_valid   = $urandom_range(0, 1);
         scan_start = ($urandom_range(0, 9) == 0);
         sel        = 3'($urandom_range(0, 7));
         #1;
         n_tests++; if (in_ready8 !== (!m_scan[0] && !scan_start) || in_ready6 !== (!m_scan[1] && !scan_start)) begin
            n_fail++; $display("FAIL rnd_in_ready cyc%0d got %b/%b want %b/%b", i, in_ready8, in_ready6, (!m_scan[0] && !scan_start), (!m_scan[1] && !scan_start));
         end
         @(posedge clk);
         #1;
         n_tests++; if (o8 !== m_o[0] || ov8 !== m_vld[0] || sd8 !== m_done[0] || err8 !== m_err[0]) begin
            n_fail++; $display("FAIL rnd_dut8 cyc%0d got o=%h v=%b d=%b e=%b want %h/%b/%b/%b", i, o8, ov8, sd8, err8, m_o[0], m_vld[0], m_done[0], m_err[0]);
         end
         n_tests++; if ({2'b00, o6} !== m_o[1] || ov6 !== m_vld[1] || sd6 !== m_done[1] || err6 !== m_err[1]) begin
            n_fail++; $display("FAIL rnd_dut6 cyc%0d got o=%h v=%b d=%b e=%b want %h/%b/%b/%b", i, o6, ov6, sd6, err6, m_o[1], m_vld[1], m_done[1], m_err[1]);
         end
      end
      idle_inputs();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_direct();
      test_scan();
      test_en_gap();
      test_range();
      test_collision();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout simulation exceeded 200000 time units");
      $fatal(1, "timeout");
   end

endmodule
